// File: rtl/cache_miss_ctrl.sv
// Miss handler behind the tag hit-check: returns hit ways, fetches and fills missing lines.
// Optional hit/miss counters are built when CACHE_MISS_STATS_EN is defined.
module cache_miss_ctrl #(
  parameter int N_WAYS     = 2,
  parameter int N_POW      = 4,
  parameter int TAG_BITS   = 20,
  parameter int INDEX_BITS = 4,
  parameter int LINE_BITS  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [TAG_BITS-1:0]            req_tag,
  input  logic [INDEX_BITS-1:0]          req_index,
  input  logic                           hit,
  input  logic                           miss,
  input  logic [N_POW-1:0]               hit_way,
  input  logic [N_WAYS-1:0]              line_empty,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_req_addr,
  input  logic                           mem_resp_valid,
  input  logic [LINE_BITS-1:0]           mem_resp_data,
  output logic                           fill_en,
  output logic [N_POW-1:0]               fill_way,
  output logic [INDEX_BITS-1:0]          fill_index,
  output logic [TAG_BITS-1:0]            fill_tag,
  output logic [LINE_BITS-1:0]           fill_data,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [N_POW-1:0]               resp_way
`ifdef CACHE_MISS_STATS_EN
  ,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
`endif
);

  localparam int SETS = 2**INDEX_BITS;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] FILL     = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic [N_POW-1:0]      victim_q, victim_d;
  logic                  rr_sel_q, rr_sel_d;
  logic [LINE_BITS-1:0]  data_q, data_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [N_POW-1:0]      resp_way_q, resp_way_d;
  logic [N_POW-1:0]      rr_q [SETS];

  logic                  accept;
  logic                  any_empty;
  logic [N_POW-1:0]      victim;
  logic [N_POW-1:0]      rr_cur;
  logic [N_POW-1:0]      rr_next;
  logic                  unused_miss;

  // hit alone decides the path; miss is only its redundant complement
  assign unused_miss = miss;

  assign accept = req_valid && (state_q == IDLE);

  // scanning downward leaves the lowest empty way selected
  always_comb begin
    any_empty = 1'b0;
    victim    = rr_q[req_index];
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (line_empty[i]) begin
        any_empty = 1'b1;
        victim    = N_POW'(i);
      end
    end
  end

  assign rr_cur  = rr_q[index_q];
  assign rr_next = (rr_cur == N_POW'(N_WAYS - 1)) ? '0 : rr_cur + 1'b1;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    index_d      = index_q;
    victim_d     = victim_q;
    rr_sel_d     = rr_sel_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    unique case (state_q)
      IDLE: begin
        if (accept && hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_way_d   = hit_way;
        end else if (accept) begin
          tag_d    = req_tag;
          index_d  = req_index;
          victim_d = victim;
          rr_sel_d = !any_empty;
          state_d  = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          data_d  = mem_resp_data;
          state_d = FILL;
        end
      end
      FILL: begin
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_way_d   = victim_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      victim_q     <= '0;
      rr_sel_q     <= 1'b0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      victim_q     <= victim_d;
      rr_sel_q     <= rr_sel_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
    end
  end

  // pointer only advances when it actually supplied the victim
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (state_q == FILL && rr_sel_q) begin
      rr_q[index_q] <= rr_next;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == MEM_REQ);
  assign mem_req_addr  = {tag_q, index_q};
  assign fill_en       = (state_q == FILL);
  assign fill_way      = victim_q;
  assign fill_index    = index_q;
  assign fill_tag      = tag_q;
  assign fill_data     = data_q;
  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_way      = resp_way_q;

`ifdef CACHE_MISS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept && hit && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (accept && !hit && miss_count != '1)
        miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Randomized self-checking bench for cache_miss_ctrl against a set/way reference model.
// Counter ports are checked when CACHE_MISS_STATS_EN is defined.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_tag;
  logic [3:0]  req_index;
  logic        hit;
  logic        miss;
  logic [3:0]  hit_way;
  logic [1:0]  line_empty;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [23:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        fill_en;
  logic [3:0]  fill_way;
  logic [3:0]  fill_index;
  logic [19:0] fill_tag;
  logic [31:0] fill_data;
  logic        resp_valid;
  logic        resp_hit;
  logic [3:0]  resp_way;
`ifdef CACHE_MISS_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_index(req_index),
    .hit(hit), .miss(miss), .hit_way(hit_way),
    .line_empty(line_empty),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_en(fill_en), .fill_way(fill_way), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way)
`ifdef CACHE_MISS_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  localparam int NW = 2;

  int n_vec = 0;
  int n_err = 0;
  int rr_m [16];
  int last_way;
  int last_hit;
  int hits_m;
  int misses_m;
  int dir_w [3] = '{1, 0, 1};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) rr_m[s] = 0;
    last_way = 0;
    last_hit = 0;
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic idle_inputs();
    req_valid      = 1'b0;
    req_tag        = '0;
    req_index      = '0;
    hit            = 1'b0;
    miss           = 1'b0;
    hit_way        = '0;
    line_empty     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  // n hits back to back; resp for hit k is seen one cycle after it is driven
  task automatic hit_burst(input int n, input bit directed);
    int w;
    for (int i = 0; i < n; i++) begin
      chk("hit_req_ready", req_ready, 1);
      chk("hit_no_memreq", mem_req_valid, 0);
      if (i > 0) begin
        chk("hit_resp_valid", resp_valid, 1);
        chk("hit_resp_hit", resp_hit, 1);
        chk("hit_resp_way", resp_way, last_way);
      end
      w = directed ? dir_w[i % 3] : int'($urandom_range(0, NW - 1));
      req_valid = 1'b1;
      hit       = 1'b1;
      miss      = 1'($urandom % 2);
      hit_way   = 4'(w);
      req_tag   = 20'($urandom);
      req_index = 4'($urandom);
      @(negedge clk);
      last_way = w;
      last_hit = 1;
      hits_m++;
    end
    req_valid = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    chk("hit_resp_valid", resp_valid, 1);
    chk("hit_resp_hit", resp_hit, 1);
    chk("hit_resp_way", resp_way, last_way);
    chk("hit_no_memreq", mem_req_valid, 0);
    @(negedge clk);
    chk("hit_idle_valid", resp_valid, 0);
    chk("hit_hold_way", resp_way, last_way);
    chk("hit_hold_hit", resp_hit, last_hit);
  endtask

  task automatic do_miss(input logic [19:0] tg, input logic [3:0] ix,
                         input logic [1:0] emp, input logic [31:0] dat,
                         input int stall, input int wait_c);
    int  vic;
    bit  by_rr;
    logic [23:0] addr;
    by_rr = 1;
    vic   = rr_m[ix];
    for (int i = NW - 1; i >= 0; i--)
      if (emp[i]) begin
        vic   = i;
        by_rr = 0;
      end
    addr = {tg, ix};
    chk("miss_req_ready", req_ready, 1);
    req_valid  = 1'b1;
    hit        = 1'b0;
    miss       = 1'b1;
    req_tag    = tg;
    req_index  = ix;
    line_empty = emp;
    hit_way    = 4'($urandom);
    @(negedge clk);
    misses_m++;
    req_valid = 1'b0;
    miss      = 1'b0;
    req_tag   = 20'($urandom);
    req_index = 4'($urandom);
    for (int c = 0; c < stall; c++) begin
      chk("mreq_valid", mem_req_valid, 1);
      chk("mreq_addr", mem_req_addr, addr);
      chk("mreq_ready_lo", req_ready, 0);
      chk("mreq_no_resp", resp_valid, 0);
      chk("mreq_no_fill", fill_en, 0);
      req_valid      = 1'($urandom % 2);
      hit            = 1'b1;
      mem_resp_valid = (c == 1) ? 1'b1 : 1'($urandom % 2);
      mem_resp_data  = $urandom;
      @(negedge clk);
    end
    chk("mreq_valid", mem_req_valid, 1);
    chk("mreq_addr", mem_req_addr, addr);
    req_valid      = 1'b0;
    hit            = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int c = 0; c < wait_c; c++) begin
      chk("mwait_no_req", mem_req_valid, 0);
      chk("mwait_no_fill", fill_en, 0);
      chk("mwait_ready_lo", req_ready, 0);
      chk("mwait_no_resp", resp_valid, 0);
      chk("mwait_hold_way", resp_way, last_way);
      req_valid = 1'($urandom % 2);
      hit       = 1'b1;
      @(negedge clk);
    end
    chk("mwait_no_req", mem_req_valid, 0);
    req_valid      = 1'b0;
    hit            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = dat;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = $urandom;
    chk("fill_en", fill_en, 1);
    chk("fill_way", fill_way, vic);
    chk("fill_index", fill_index, ix);
    chk("fill_tag", fill_tag, tg);
    chk("fill_data", fill_data, dat);
    chk("fill_ready_lo", req_ready, 0);
    chk("fill_no_resp", resp_valid, 0);
    @(negedge clk);
    chk("fill_pulse_end", fill_en, 0);
    chk("mresp_valid", resp_valid, 1);
    chk("mresp_hit", resp_hit, 0);
    chk("mresp_way", resp_way, vic);
    chk("mresp_ready", req_ready, 1);
    if (by_rr) rr_m[ix] = (rr_m[ix] + 1) % NW;
    last_way = vic;
    last_hit = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_memreq", mem_req_valid, 0);
    chk("rst_fill", fill_en, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_addr", mem_req_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    hit_burst(3, 1'b1);

    do_miss(20'hABCDE, 4'd3, 2'b10, 32'hDEADBEEF, 1, 1);
    chk("cold_addr", mem_req_addr, 24'hABCDE3);

    for (int k = 0; k < 3; k++)
      do_miss(20'($urandom), 4'd5, 2'b00, $urandom, 0, 0);
    do_miss(20'($urandom), 4'd3, 2'b00, $urandom, 0, 0);

    do_miss(20'h12345, 4'd9, 2'b00, 32'hCAFEF00D, 4, 2);

    for (int k = 0; k < 40; k++) begin
      if ($urandom % 2) begin
        hit_burst(int'($urandom_range(1, 4)), 1'b0);
      end else begin
        do_miss(20'($urandom), 4'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
                $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end
    end

    req_valid  = 1'b1;
    hit        = 1'b0;
    miss       = 1'b1;
    req_tag    = 20'h55555;
    req_index  = 4'd7;
    line_empty = 2'b00;
    @(negedge clk);
    req_valid     = 1'b0;
    miss          = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("pre_rst_wait", mem_req_valid, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_fill", fill_en, 0);
    chk("arst_resp", resp_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BADF00D;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fill", fill_en, 0);
    chk("post_rst_resp", resp_valid, 0);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_memreq", mem_req_valid, 0);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_fill2", fill_en, 0);
    chk("post_rst_resp2", resp_valid, 0);

    hit_burst(5, 1'b0);
    do_miss(20'h00001, 4'd7, 2'b00, 32'h11111111, 0, 0);
    do_miss(20'h00002, 4'd7, 2'b00, 32'h22222222, 1, 0);
`ifdef CACHE_MISS_STATS_EN
    chk("stat_hits", hit_count, 5);
    chk("stat_misses", miss_count, 2);
    chk("stat_hits_m", hit_count, hits_m);
    chk("stat_misses_m", miss_count, misses_m);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
- Sits directly downstream of the tag hit-check stage.
- Takes the hit/miss/hit_way verdict for each accepted lookup and returns a way on hits.
- On a miss it picks a victim way, fetches the line from memory over a valid/ready handshake, and issues a one-cycle fill write into the tag/data arrays.
- Keeps per-set round-robin replacement state and reports every lookup result to the requester.

Parameters:
- N_WAYS, 2, associativity; 2 to 16.
- N_POW, 4, way-index width; 2**N_POW >= N_WAYS.
- TAG_BITS, 20, tag width.
- INDEX_BITS, 4, set-index width; the block tracks 2**INDEX_BITS sets.
- LINE_BITS, 32, cache line data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  block can accept a lookup.
- req_tag  in  TAG_BITS  lookup tag.
- req_index  in  INDEX_BITS  lookup set.
- hit  in  1  hit-check verdict for req_tag/req_index, same cycle.
- miss  in  1  inverse of hit.
- hit_way  in  N_POW  hitting way.
- line_empty  in  N_WAYS  per-way empty flags of set req_index.
- mem_req_valid  out  1  line fetch request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  TAG_BITS+INDEX_BITS  {tag,index} of missing line.
- mem_resp_valid  in  1  fetched line valid.
- mem_resp_data  in  LINE_BITS  fetched line.
- fill_en  out  1  one-cycle array write strobe.
- fill_way  out  N_POW  way to write.
- fill_index  out  INDEX_BITS  set to write.
- fill_tag  out  TAG_BITS  tag to write; fill also clears the way's empty flag.
- fill_data  out  LINE_BITS  data to write.
- resp_valid  out  1  lookup result valid, one-cycle pulse.
- resp_hit  out  1  1 = hit, 0 = filled miss.
- resp_way  out  N_POW  way holding the line.

Behaviour:
- Reset:
  - State goes to IDLE; all round-robin pointers clear to 0.
  - mem_req_valid, fill_en, resp_valid and resp_hit reset to 0; all other outputs reset to 0.
  - Reset mid-miss abandons the fetch; no fill is issued and no response is returned.
  - A mem_resp_valid arriving after reset is ignored.
- States: IDLE, MEM_REQ, MEM_WAIT, FILL.
- IDLE:
  - req_ready = 1. A request is accepted when req_valid && req_ready.
  - Accept with hit=1: next cycle resp_valid=1, resp_hit=1, resp_way=hit_way; remain in IDLE. Back-to-back hits sustain one per cycle.
  - Accept with hit=0:
    - Latch tag and index.
    - Victim = lowest-numbered way with line_empty=1; if no way is empty, victim = rr[index].
    - Record whether the round-robin pointer chose the victim, then go to MEM_REQ.
  - If hit and miss are both 1, hit takes precedence.
- MEM_REQ:
  - req_ready = 0; mem_req_valid = 1.
  - mem_req_addr = {latched tag, latched index}, held stable until the handshake completes.
  - On mem_req_ready, go to MEM_WAIT; mem_req_valid drops the next cycle.
- MEM_WAIT: req_ready = 0. On mem_resp_valid, capture mem_resp_data and go to FILL. mem_resp_valid in any other state is ignored.
- FILL:
  - fill_en = 1 for exactly one cycle, with fill_way/fill_index/fill_tag/fill_data driven from the latched values.
  - If the round-robin pointer chose the victim: rr[index] <= (rr[index] == N_WAYS-1) ? 0 : rr[index]+1. The pointer wraps at N_WAYS, not at 2**N_POW.
  - Schedule the response and return to IDLE.
  - Next cycle: resp_valid=1, resp_hit=0, resp_way=victim, and req_ready=1, so a new lookup may be accepted that same cycle and sees the filled tag.
- Latencies: hit response 1 cycle after acceptance; miss response = 3 + memory handshake cycles minimum.
- When resp_valid=0, resp_hit and resp_way hold their last values.

Optional Feature:
- Macro: CACHE_MISS_STATS_EN.
- Defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each accepted hit; miss_count increments on each accepted miss.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Hit stream: reset, then 3 consecutive accepted requests with hit=1, hit_way=1,0,1 -> resp_valid on 3 consecutive cycles with resp_way 1,0,1, resp_hit=1; mem_req_valid stays 0.
- Cold miss with empty way: line_empty=2'b10, miss, tag=20'hABCDE, index=3 ->
  - mem_req_addr=24'hABCDE3.
  - After mem_resp_data=32'hDEADBEEF: fill_en pulse with way=1, index=3, tag=20'hABCDE, data=32'hDEADBEEF.
  - Then resp_valid with resp_hit=0, resp_way=1.
  - rr[3] unchanged (0).
- Round-robin wrap: N_WAYS=2, set 5 full, three misses -> victims 0,1,0; pointers for other sets remain 0.
- Handshake stall: hold mem_req_ready=0 for 4 cycles -> mem_req_valid and mem_req_addr stable throughout; req_ready=0; a stray mem_resp_valid during MEM_REQ is ignored.
- Reset in MEM_WAIT: assert rst, then drive mem_resp_valid -> no fill_en, no resp_valid, req_ready=1 after release.
- With CACHE_MISS_STATS_EN: 5 hits and 2 misses -> hit_count=5, miss_count=2.
